// File: rtl/clkdiv_pkg.sv
// Shared definitions for the 4-channel clock divide/select block and its
// serial configuration front-end.
package clkdiv_pkg;

  localparam int unsigned CFG_W     = 35;
  localparam int unsigned CNT_W     = 6;

  localparam int unsigned SEL_LSB   = 0;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned DIV_W     = 8;
  localparam int unsigned DIV_A_LSB = 2;
  localparam int unsigned DIV_B_LSB = 10;
  localparam int unsigned DIV_C_LSB = 18;
  localparam int unsigned DIV_D_LSB = 26;
  localparam int unsigned EN_BIT    = 34;

  // Packed view of the configuration word, MSB (enable) first.
  typedef struct packed {
    logic             en;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] div_c;
    logic [DIV_W-1:0] div_b;
    logic [DIV_W-1:0] div_a;
    logic [SEL_W-1:0] sel;
  } clkdiv_cfg_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-stage synchronizer for an asynchronous input with a one-cycle
// rising-edge pulse on the synchronized level.
module sync_rise_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync_out = r_sync[SYNC_STAGES-1];
  assign rise     = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/cfg_serial_loader.sv
// Serial (sclk/sdata/latch) loader that assembles the divider configuration
// word and commits it atomically only when exactly CFG_W bits were shifted.
module cfg_serial_loader #(
  parameter int unsigned CFG_W       = clkdiv_pkg::CFG_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk_in,
  input  logic                         sdata_in,
  input  logic                         latch_in,
  output logic [CFG_W-1:0]             cfg_out,
  output logic                         cfg_valid,
  output logic                         cfg_error,
  output logic [clkdiv_pkg::CNT_W-1:0] bit_count
);

  import clkdiv_pkg::CNT_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_W + 1);

  logic                   w_sclk_rise;
  logic                   w_latch_rise;
  logic                   w_sclk_sync_unused;
  logic                   w_latch_sync_unused;
  logic                   w_sdata_sync;
  logic [SYNC_STAGES-1:0] r_sdata_pipe;
  logic [CFG_W-1:0]       r_shadow;
  logic [CFG_W-1:0]       w_shadow_nxt;
  logic [CFG_W-1:0]       r_cfg;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_nxt;
  logic                   r_valid;
  logic                   r_error;

  sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sclk_in),
    .sync_out (w_sclk_sync_unused),
    .rise     (w_sclk_rise)
  );

  sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (latch_in),
    .sync_out (w_latch_sync_unused),
    .rise     (w_latch_rise)
  );

  // Data rides a pipe of the same depth so it stays aligned with its clock.
  assign w_sdata_sync = r_sdata_pipe[SYNC_STAGES-1];

  // Post-shift view: a same-cycle latch sees the bit shifted this cycle.
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_count_nxt  = r_count;
    if (w_sclk_rise) begin
      w_shadow_nxt = {r_shadow[CFG_W-2:0], w_sdata_sync};
      if (r_count != CNT_MAX) begin
        w_count_nxt = r_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sdata_pipe <= '0;
      r_shadow     <= '0;
      r_count      <= '0;
      r_cfg        <= '0;
      r_valid      <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_sdata_pipe <= {r_sdata_pipe[SYNC_STAGES-2:0], sdata_in};
      r_shadow     <= w_shadow_nxt;
      r_valid      <= 1'b0;
      r_error      <= 1'b0;
      if (w_latch_rise) begin
        r_count <= '0;
        if (w_count_nxt == CNT_FULL) begin
          r_cfg   <= w_shadow_nxt;
          r_valid <= 1'b1;
        end else begin
          r_error <= 1'b1;
        end
      end else begin
        r_count <= w_count_nxt;
      end
    end
  end

  assign cfg_out   = r_cfg;
  assign cfg_valid = r_valid;
  assign cfg_error = r_error;
  assign bit_count = r_count;

endmodule

// File: tb/tb_cfg_serial_loader.sv
// Randomized self-checking bench for cfg_serial_loader against a word-level
// reference model (integer shift arithmetic, saturating bit count).
`timescale 1ns/1ps
module tb_cfg_serial_loader;

  localparam int unsigned W = 35;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk_in = 1'b0;
  logic          sdata_in = 1'b0;
  logic          latch_in = 1'b0;
  logic [W-1:0]  cfg_out;
  logic          cfg_valid;
  logic          cfg_error;
  logic [5:0]    bit_count;

  cfg_serial_loader #(.CFG_W(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk_in   (sclk_in),
    .sdata_in  (sdata_in),
    .latch_in  (latch_in),
    .cfg_out   (cfg_out),
    .cfg_valid (cfg_valid),
    .cfg_error (cfg_error),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  longint unsigned m_shadow = 0;
  longint unsigned m_cfg    = 0;
  int              m_count  = 0;
  int              exp_valid_total = 0;
  int              exp_error_total = 0;

  // pulse / stability monitor
  int              n_valid = 0;
  int              n_error = 0;
  int              n_both  = 0;
  int              n_bad_change = 0;
  logic [W-1:0]    prev_cfg;

  always @(negedge clk) begin
    if (cfg_valid) n_valid++;
    if (cfg_error) n_error++;
    if (cfg_valid && cfg_error) n_both++;
    if (!$isunknown(prev_cfg) && cfg_out !== prev_cfg && !cfg_valid && !rst)
      n_bad_change++;
    prev_cfg = cfg_out;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One serial slot: optional sclk rise and/or latch rise in the same clk cycle.
  task automatic step(input logic b, input bit do_sclk, input bit do_latch);
    logic            exp_v;
    logic            exp_e;
    longint unsigned old_cfg;
    sdata_in = b;
    repeat (2) @(posedge clk);
    #1;
    exp_v   = 1'b0;
    exp_e   = 1'b0;
    old_cfg = m_cfg;
    if (do_sclk) begin
      sclk_in  = 1'b1;
      m_shadow = ((m_shadow << 1) | longint'(b)) & MASK;
      if (m_count < W + 1) m_count++;
    end
    if (do_latch) begin
      latch_in = 1'b1;
      if (m_count == W) begin
        exp_v = 1'b1;
        m_cfg = m_shadow;
        exp_valid_total++;
      end else begin
        exp_e = 1'b1;
        exp_error_total++;
      end
      m_count = 0;
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (do_latch) begin
        check_eq("pulse_early", {62'd0, cfg_valid, cfg_error}, 64'd0);
        check_eq("cfg_early", 64'(cfg_out), old_cfg);
      end
    end
    @(posedge clk); #1;
    if (do_latch) begin
      check_eq("cfg_valid", 64'(cfg_valid), 64'(exp_v));
      check_eq("cfg_error", 64'(cfg_error), 64'(exp_e));
      check_eq("cfg_out", 64'(cfg_out), m_cfg);
    end
    @(posedge clk); #1;
    if (do_latch)
      check_eq("pulse_width", {62'd0, cfg_valid, cfg_error}, 64'd0);
    sclk_in  = 1'b0;
    latch_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("bit_count", 64'(bit_count), 64'(m_count));
    check_eq("cfg_hold", 64'(cfg_out), m_cfg);
  endtask

  task automatic shift_bits(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) step(w[i], 1'b1, 1'b0);
  endtask

  // n bits; the last one optionally shares its cycle with the latch
  task automatic load(input logic [63:0] w, input int n, input bit simul);
    if (simul && n > 0) begin
      shift_bits(w >> 1, n - 1);
      step(w[0], 1'b1, 1'b1);
    end else begin
      shift_bits(w, n);
      step(1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic pulse_quiet(input string tag, input int cycles);
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_error;
    repeat (cycles) @(posedge clk);
    #1;
    check_eq(tag, 64'((n_valid - v0) + (n_error - e0)), 64'd0);
  endtask

  task automatic do_reset();
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_error;
    @(posedge clk); #1;
    latch_in = 1'b1;             // latch edge caught in the synchronizer
    @(posedge clk); #1;
    rst = 1'b1;
    latch_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cfg", 64'(cfg_out), 64'd0);
    check_eq("rst_count", 64'(bit_count), 64'd0);
    rst = 1'b0;
    m_shadow = 0;
    m_cfg    = 0;
    m_count  = 0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("rst_no_pulse", 64'((n_valid - v0) + (n_error - e0)), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] w;
    int          kind;
    int          n;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_cfg", 64'(cfg_out), 64'd0);
    check_eq("reset_count", 64'(bit_count), 64'd0);
    check_eq("reset_pulses", {62'd0, cfg_valid, cfg_error}, 64'd0);
    rst = 1'b0;
    pulse_quiet("release_quiet", 10);
    check_eq("release_cfg", 64'(cfg_out), 64'd0);

    // latch with nothing shifted
    step(1'b0, 1'b0, 1'b1);

    load(64'h5_A5A5_A5A5, 35, 1'b0);
    check_eq("pattern_cfg", 64'(cfg_out), 64'h5_A5A5_A5A5);

    load(64'h2AB, 10, 1'b0);
    check_eq("short_keep", 64'(cfg_out), 64'h5_A5A5_A5A5);

    shift_bits(64'hF_0F0F_0F0F, 36);
    check_eq("ovf_count", 64'(bit_count), 64'd36);
    step(1'b0, 1'b0, 1'b1);
    check_eq("ovf_keep", 64'(cfg_out), 64'h5_A5A5_A5A5);
    load(64'h3_1234_5678, 35, 1'b0);
    check_eq("after_ovf_cfg", 64'(cfg_out), 64'h3_1234_5678);

    load(64'h4_0000_0001, 35, 1'b1);
    check_eq("simul_lsb", 64'(cfg_out[0]), 64'd1);
    check_eq("simul_cfg", 64'(cfg_out), 64'h4_0000_0001);

    shift_bits(64'hF_FFFF_FFFF, 20);
    do_reset();
    load(64'h1_2345_6789, 35, 1'b0);
    check_eq("fresh_cfg", 64'(cfg_out), 64'h1_2345_6789);

    for (int it = 0; it < 14; it++) begin
      w    = {32'($urandom), 32'($urandom)};
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       n = W;
        1:       n = W;
        2:       n = int'($urandom_range(0, W - 1));
        default: n = int'($urandom_range(W + 1, W + 5));
      endcase
      load(w, n, kind == 1 || (kind != 0 && $urandom_range(0, 1) == 1));
    end

    repeat (5) @(posedge clk);
    #1;
    check_eq("total_valid", 64'(n_valid), 64'(exp_valid_total));
    check_eq("total_error", 64'(n_error), 64'(exp_error_total));
    check_eq("exclusive", 64'(n_both), 64'd0);
    check_eq("cfg_stable", 64'(n_bad_change), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
